i2s_sample_rx: RTL

I2S_SAMPLE_RX -- requirements
Module: i2s_sample_rx

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_sync_edge.sv | 27 ++
 rtl/i2s_sample_rx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Purpose: shared widths and FSM state encoding for the I2S sample receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;
   localparam int SAMPLE_W = 16;
   localparam int CNT_W    = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAIT  = 2'd2
   } state_t;
endpackage

// File: rtl/i2s_sync_edge.sv
// Purpose: bring an asynchronous bit clock into the clk domain and flag its rising edges.
// Latency: SYNC_STAGES clk from input rise to the one-cycle rise flag.
// Backpressure: none; the rise flag is a free-running strobe.
module i2s_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Synchronizer chain plus one flop holding the previous synchronized level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/i2s_sample_rx.sv
// Purpose: deserialize I2S words (MSB first) into signed 16-bit samples with channel tag.
// Latency: SYNC_STAGES+1 clk from the sck rise carrying the 16th bit to sample_valid.
// Backpressure: none; every sample_valid pulse must be taken by the consumer.
module i2s_sample_rx
   import i2s_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int RIGHT_EN    = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i2s_sck,
   input  logic                       i2s_ws,
   input  logic                       i2s_sd,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       sample_valid,
   output logic                       sample_right,
   output logic                       frame_err
);
   logic [SYNC_STAGES-1:0] ws_sync;
   logic [SYNC_STAGES-1:0] sd_sync;
   logic                   ws_s;
   logic                   sd_s;
   logic                   sck_rise;
   logic                   ws_prev;
   logic                   ws_edge;
   logic                   chan;
   logic [CNT_W-1:0]       bit_cnt;
   logic [SAMPLE_W-2:0]    shreg;
   state_t                 state;
   state_t                 state_n;
   logic                   start;
   logic                   shift_en;
   logic                   word_done;
   logic                   short_err;

   i2s_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sck_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (i2s_sck),
      .rise  (sck_rise)
   );

   // ws and sd go through chains of the same depth as sck so all three stay aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ws_sync <= '0;
         sd_sync <= '0;
      end else begin
         ws_sync <= {ws_sync[SYNC_STAGES-2:0], i2s_ws};
         sd_sync <= {sd_sync[SYNC_STAGES-2:0], i2s_sd};
      end
   end

   assign ws_s    = ws_sync[SYNC_STAGES-1];
   assign sd_s    = sd_sync[SYNC_STAGES-1];
   assign ws_edge = sck_rise && (ws_s != ws_prev);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next state and datapath strobes; the bit at a WS-edge rise is the old word's tail and is dropped.
   always_comb begin
      state_n   = state;
      start     = 1'b0;
      shift_en  = 1'b0;
      word_done = 1'b0;
      short_err = 1'b0;
      case (state)
         IDLE: begin
            if (ws_edge) begin
               state_n = SHIFT;
               start   = 1'b1;
            end
         end
         SHIFT: begin
            if (ws_edge) begin
               start     = 1'b1;
               short_err = (bit_cnt < CNT_W'(SAMPLE_W));
            end else if (sck_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == CNT_W'(SAMPLE_W - 1)) begin
                  word_done = 1'b1;
                  state_n   = WAIT;
               end
            end
         end
         WAIT: begin
            if (ws_edge) begin
               state_n = SHIFT;
               start   = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Shift register, bit counter, channel latch and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ws_prev      <= 1'b0;
         chan         <= 1'b0;
         bit_cnt      <= '0;
         shreg        <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         sample_right <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         frame_err    <= short_err;
         if (sck_rise) ws_prev <= ws_s;
         if (start) begin
            chan    <= ws_s;
            bit_cnt <= '0;
            shreg   <= '0;
         end else if (shift_en) begin
            shreg   <= {shreg[SAMPLE_W-3:0], sd_s};
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
         // Right words still complete the FSM cycle when suppressed, they just never reach the output.
         if (word_done && ((RIGHT_EN != 0) || !chan)) begin
            sample_out   <= {shreg, sd_s};
            sample_right <= chan;
            sample_valid <= 1'b1;
         end
      end
   end
endmodule
